// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns per-channel LED on/off requests into linear PWM fades.
// Define LED_ACTIVE_LOW_EN to drive active-low LED pins (settled is unaffected).
module led_pwm_fader #(
  parameter int N_CH     = 2,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] led_in,
  output logic [N_CH-1:0] led_out,
  output logic            settled
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] ZERO = '0;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(STEP_DIV - 1);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [N_CH-1:0] OUT_INV = '1;
`else
  localparam logic [N_CH-1:0] OUT_INV = '0;
`endif

  logic [N_CH-1:0]     led_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] duty     [N_CH];
  logic [PWM_BITS-1:0] duty_nxt [N_CH];

  logic            step_tick;
  logic [N_CH-1:0] drive;
  logic            all_set;

  assign step_tick = (div_cnt == DIV_LAST);

  // Saturating ramp toward the requested end; a reversal
  // simply continues from wherever duty currently is.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      duty_nxt[c] = duty[c];
      if (step_tick) begin
        if (led_q[c] && duty[c] != MAX) begin
          duty_nxt[c] = duty[c] + 1'b1;
        end else if (!led_q[c] && duty[c] != ZERO) begin
          duty_nxt[c] = duty[c] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    drive   = '0;
    all_set = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      drive[c] = (duty[c] == MAX) || (duty[c] > pwm_cnt);
      if (duty[c] != (led_q[c] ? MAX : ZERO)) begin
        all_set = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
      led_out <= OUT_INV;
      settled <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        duty[c] <= '0;
      end
    end else begin
      led_q   <= led_in;
      pwm_cnt <= pwm_cnt + 1'b1;
      div_cnt <= step_tick ? '0 : div_cnt + 1'b1;
      led_out <= drive ^ OUT_INV;
      settled <= all_set;
      for (int c = 0; c < N_CH; c++) begin
        duty[c] <= duty_nxt[c];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed bench for led_pwm_fader.
// Main instance uses STEP_DIV=4; a STEP_DIV=16 instance holds duty per frame.
module tb_led_pwm_fader;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [1:0] INV = 2'b11;
`else
  localparam logic [1:0] INV = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] led_in = 2'b00;
  logic [1:0] led_out;
  logic       settled;

  logic       rst_s = 1'b1;
  logic [1:0] led_in_s = 2'b00;
  logic [1:0] led_out_s;
  logic       settled_s;

  int checks = 0;
  int failures = 0;

  // reference state for the main instance
  logic [1:0] m_lq;
  logic [3:0] m_pwm;
  logic [1:0] m_div;
  logic [3:0] m_duty [2];
  logic [1:0] m_out;
  logic       m_set;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .N_CH(2), .PWM_BITS(4), .STEP_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .led_in(led_in),
    .led_out(led_out), .settled(settled)
  );

  led_pwm_fader #(
    .N_CH(2), .PWM_BITS(4), .STEP_DIV(16)
  ) dut_slow (
    .clk(clk), .rst(rst_s), .led_in(led_in_s),
    .led_out(led_out_s), .settled(settled_s)
  );

  task automatic tick();
    logic [1:0] li;
    logic       r;
    logic [1:0] n_out;
    logic       n_set;
    li = led_in;
    r  = rst;
    @(posedge clk);
    if (r) begin
      m_lq = 2'b00; m_pwm = 4'd0; m_div = 2'd0;
      m_duty[0] = 4'd0; m_duty[1] = 4'd0;
      m_out = 2'b00; m_set = 1'b1;
    end else begin
      n_set = 1'b1;
      n_out = 2'b00;
      for (int c = 0; c < 2; c++) begin
        n_out[c] = (m_duty[c] == 4'd15) || (m_duty[c] > m_pwm);
        if (m_duty[c] != (m_lq[c] ? 4'd15 : 4'd0)) n_set = 1'b0;
      end
      if (m_div == 2'd3) begin
        for (int c = 0; c < 2; c++) begin
          if (m_lq[c] && m_duty[c] != 4'd15)
            m_duty[c] = m_duty[c] + 4'd1;
          else if (!m_lq[c] && m_duty[c] != 4'd0)
            m_duty[c] = m_duty[c] - 4'd1;
        end
      end
      m_out = n_out;
      m_set = n_set;
      m_div = (m_div == 2'd3) ? 2'd0 : m_div + 2'd1;
      m_pwm = m_pwm + 4'd1;
      m_lq  = li;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    led_in = 2'b11;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (led_out !== INV || settled !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d led_out=%b settled=%b exp %b/1",
                 i, led_out, settled, INV);
      end
    end
    led_in = 2'b00;
    rst = 1'b0;
    tick();
    checks++;
    if (led_out !== INV || settled !== 1'b1) begin
      failures++;
      $display("FAIL reset_release led_out=%b settled=%b exp %b/1",
               led_out, settled, INV);
    end
  endtask

  task automatic test_fade_in();
    do_reset();
    led_in = 2'b01;
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (led_out !== (m_out ^ INV) || settled !== m_set) begin
        failures++;
        $display("FAIL fade_in k=%0d led_out=%b settled=%b exp %b/%b",
                 k, led_out, settled, m_out ^ INV, m_set);
      end
      checks++;
      if (led_out[1] !== INV[1]) begin
        failures++;
        $display("FAIL fade_in_ch1_off k=%0d got=%b exp=%b",
                 k, led_out[1], INV[1]);
      end
      if (k == 60) begin
        checks++;
        if (settled !== 1'b0) begin
          failures++;
          $display("FAIL fade_in_not_done k=60 settled=%b exp=0", settled);
        end
      end
      if (k == 61) begin
        checks++;
        if (settled !== 1'b1) begin
          failures++;
          $display("FAIL fade_in_done k=61 settled=%b exp=1", settled);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (led_out !== (2'b01 ^ INV) || settled !== 1'b1) begin
        failures++;
        $display("FAIL fade_in_solid k=%0d led_out=%b settled=%b exp %b/1",
                 k, led_out, settled, 2'b01 ^ INV);
      end
    end
  endtask

  task automatic test_opposite();
    led_in = 2'b10;
    for (int k = 1; k <= 70; k++) begin
      tick();
      checks++;
      if (led_out !== (m_out ^ INV) || settled !== m_set) begin
        failures++;
        $display("FAIL opposite k=%0d led_out=%b settled=%b exp %b/%b",
                 k, led_out, settled, m_out ^ INV, m_set);
      end
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (led_out !== (2'b10 ^ INV) || settled !== 1'b1) begin
        failures++;
        $display("FAIL opposite_solid k=%0d led_out=%b settled=%b exp %b/1",
                 k, led_out, settled, 2'b10 ^ INV);
      end
    end
  endtask

  task automatic test_duty_fidelity();
    int cnt;
    int exp_cnt;
    rst_s = 1'b1;
    tick();
    tick();
    led_in_s = 2'b01;
    rst_s = 1'b0;
    // duty m is held for the frame on edges 16m+1..16m+16
    for (int k = 0; k < 16; k++) tick();
    for (int m = 1; m <= 15; m++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        cnt += int'(led_out_s[0] ^ INV[0]);
        checks++;
        if (led_out_s[1] !== INV[1]) begin
          failures++;
          $display("FAIL fidelity_ch1 m=%0d got=%b exp=%b",
                   m, led_out_s[1], INV[1]);
        end
      end
      exp_cnt = (m == 15) ? 16 : m;
      checks++;
      if (cnt != exp_cnt) begin
        failures++;
        $display("FAIL fidelity_count duty=%0d active=%0d exp=%0d",
                 m, cnt, exp_cnt);
      end
      checks++;
      if (settled_s !== (m == 15)) begin
        failures++;
        $display("FAIL fidelity_settled duty=%0d got=%b exp=%b",
                 m, settled_s, m == 15);
      end
    end
    rst_s = 1'b1;
  endtask

  task automatic test_reversal();
    do_reset();
    led_in = 2'b01;
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) tick();
    checks++;
    if (m_duty[0] !== 4'd8) begin
      failures++;
      $display("FAIL reversal_setup duty=%0d exp=8", m_duty[0]);
    end
    led_in = 2'b00;
    for (int k = 33; k <= 70; k++) begin
      tick();
      checks++;
      if (led_out !== (m_out ^ INV) || settled !== m_set) begin
        failures++;
        $display("FAIL reversal k=%0d led_out=%b settled=%b exp %b/%b",
                 k, led_out, settled, m_out ^ INV, m_set);
      end
      if (k == 64) begin
        checks++;
        if (settled !== 1'b0) begin
          failures++;
          $display("FAIL reversal_not_done k=64 settled=%b exp=0", settled);
        end
      end
      if (k == 65) begin
        checks++;
        if (settled !== 1'b1 || led_out !== INV) begin
          failures++;
          $display("FAIL reversal_done k=65 settled=%b led_out=%b exp 1/%b",
                   settled, led_out, INV);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fade();
    do_reset();
    led_in = 2'b01;
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (led_out !== INV || settled !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset led_out=%b settled=%b exp %b/1",
               led_out, settled, INV);
    end
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (led_out !== (m_out ^ INV) || settled !== m_set) begin
        failures++;
        $display("FAIL restart k=%0d led_out=%b settled=%b exp %b/%b",
                 k, led_out, settled, m_out ^ INV, m_set);
      end
      if (k <= 4) begin
        checks++;
        if (led_out[0] !== INV[0]) begin
          failures++;
          $display("FAIL restart_from_zero k=%0d got=%b exp=%b",
                   k, led_out[0], INV[0]);
        end
      end
      if (k == 60 || k == 61) begin
        checks++;
        if (settled !== (k == 61)) begin
          failures++;
          $display("FAIL restart_settle k=%0d settled=%b exp=%b",
                   k, settled, k == 61);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_opposite();
    test_duty_fidelity();
    test_reversal();
    test_reset_mid_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
